// File: rtl/bisect_pkg.sv
// Shared types and constants for the bisection square-root sequencer.
// Adder latency is clamped to its legal range before use.
package bisect_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MID,
    SQ,
    CMP,
    DONE
  } state_e;

  localparam int DW_DEF = 8;
  localparam int RW_DEF = DW_DEF / 2;

  function automatic int add_lat_chk(input int lat);
    return (lat < 1) ? 1 : lat;
  endfunction

endpackage

// File: rtl/bisect_sqrt_ctrl_if.sv
// Request/result bundle plus shared-adder port of the sqrt sequencer.
// slave = the controller, master = register logic / adder side.
interface bisect_sqrt_ctrl_if
  import bisect_pkg::*;
#(
  parameter int DW = DW_DEF
) ();
  localparam int RW = DW / 2;

  logic          start;
  logic [DW-1:0] target;
  logic          busy;
  logic          done;
  logic [RW-1:0] root;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic [DW-1:0] add_sum;

  modport slave (
    input  start, target, add_sum,
    output busy, done, root, add_a, add_b
  );

  modport master (
    output start, target, add_sum,
    input  busy, done, root, add_a, add_b
  );
endinterface

// File: rtl/bisect_add_issue.sv
// Holds adder operands for ADD_LAT+1 cycles and flags the capture cycle.
// A new request on the capture edge chains straight into the next op.
module bisect_add_issue
  import bisect_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int ADD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] add_sum_i,
  output logic [DW-1:0] add_a_o,
  output logic [DW-1:0] add_b_o,
  output logic          sum_valid_o,
  output logic [DW-1:0] sum_o
);
  localparam int CW = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(ADD_LAT);

  logic [DW-1:0] a_q, b_q;
  logic [CW-1:0] cnt_q;
  logic          act_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else if (req_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      cnt_q <= '0;
      act_q <= 1'b1;
    end else if (act_q) begin
      if (cnt_q == LAST) begin
        a_q   <= '0;
        b_q   <= '0;
        act_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign add_a_o     = a_q;
  assign add_b_o     = b_q;
  assign sum_valid_o = act_q && (cnt_q == LAST);
  assign sum_o       = add_sum_i;
endmodule

// File: rtl/bisect_sqrt_ctrl.sv
// floor(sqrt(N)) by bisection; every add, including mid*mid built by
// repeated addition, is sequenced onto the external shared adder.
module bisect_sqrt_ctrl
  import bisect_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int ADD_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  bisect_sqrt_ctrl_if.slave bus
);
  localparam int RW  = DW / 2;
  localparam int LAT = add_lat_chk(ADD_LAT);
  localparam logic [RW:0] HI0 = {1'b1, {RW{1'b0}}};

  state_e        state_q;
  logic [DW-1:0] n_q, acc_q;
  logic [RW-1:0] lo_q, mid_q, cnt_q, root_q;
  logic [RW:0]   hi_q;
  logic          busy_q, done_q;

  logic          req;
  logic [DW-1:0] op_a, op_b, sum_w;
  logic          sv;
  logic [RW-1:0] mid_w, lo_d;
  logic [RW:0]   hi_d;
  logic          le, fin;

  bisect_add_issue #(.DW(DW), .ADD_LAT(LAT)) u_issue (
    .clock       (clock),
    .reset       (reset),
    .req_i       (req),
    .a_i         (op_a),
    .b_i         (op_b),
    .add_sum_i   (bus.add_sum),
    .add_a_o     (bus.add_a),
    .add_b_o     (bus.add_b),
    .sum_valid_o (sv),
    .sum_o       (sum_w)
  );

  assign mid_w = sum_w[RW:1];
  assign le    = (acc_q <= n_q);
  assign lo_d  = le ? mid_q : lo_q;
  assign hi_d  = le ? hi_q : {1'b0, mid_q};
  assign fin   = (hi_d - {1'b0, lo_d}) == (RW + 1)'(1);

  // Next op is issued on the edge that captures the current sum.
  always_comb begin
    req  = 1'b0;
    op_a = '0;
    op_b = '0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        req  = 1'b1;
        op_b = DW'(HI0);
      end
      MID: if (sv) begin
        req  = 1'b1;
        op_b = DW'(mid_w);
      end
      SQ: if (sv && cnt_q != RW'(1)) begin
        req  = 1'b1;
        op_a = sum_w;
        op_b = DW'(mid_q);
      end
      CMP: if (!fin) begin
        req  = 1'b1;
        op_a = DW'(lo_d);
        op_b = DW'(hi_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      mid_q   <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          n_q     <= bus.target;
          lo_q    <= '0;
          hi_q    <= HI0;
          busy_q  <= 1'b1;
          state_q <= MID;
        end
        MID: if (sv) begin
          mid_q   <= mid_w;
          cnt_q   <= mid_w;
          acc_q   <= '0;
          state_q <= SQ;
        end
        SQ: if (sv) begin
          acc_q <= sum_w;
          cnt_q <= cnt_q - RW'(1);
          if (cnt_q == RW'(1)) state_q <= CMP;
        end
        CMP: begin
          lo_q <= lo_d;
          hi_q <= hi_d;
          if (fin) begin
            root_q  <= lo_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            state_q <= MID;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.root = root_q;
endmodule
